lvds_tx: RTL and testbench



---
 rtl/lvds_tx_pkg.sv | 55 +++++
 rtl/lvds_tx.sv | 109 ++++++++++
 tb/tb_lvds_tx.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lvds_tx_pkg.sv
// Shared LVDS modem framing definitions: sync patterns, frame field positions,
// FIFO word layout and serializer state encoding (also used by lvds_rx).
package lvds_tx_pkg;

  localparam int FRAME_W      = 32;
  localparam int SAMPLE_W     = 13;
  localparam int FRAME_PHASES = 16;
  localparam int PHASE_W      = 4;

  localparam logic [1:0]        LVDS_I_SYNC    = 2'b10;
  localparam logic [1:0]        LVDS_Q_SYNC    = 2'b01;
  localparam logic              LVDS_CTRL_BIT  = 1'b0;
  localparam logic [FRAME_W-1:0] LVDS_IDLE_WORD = 32'h0000_0000;

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(FRAME_PHASES - 1);

  // Frame field positions, MSB is sent first.
  localparam int FR_IS_MSB = 31;
  localparam int FR_IS_LSB = 30;
  localparam int FR_I_MSB  = 29;
  localparam int FR_I_LSB  = 17;
  localparam int FR_CTRL   = 16;
  localparam int FR_QS_MSB = 15;
  localparam int FR_QS_LSB = 14;
  localparam int FR_Q_MSB  = 13;
  localparam int FR_Q_LSB  = 1;

  localparam int FIFO_I_MSB = 28;
  localparam int FIFO_I_LSB = 16;
  localparam int FIFO_Q_MSB = 12;
  localparam int FIFO_Q_LSB = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } tx_state_t;

  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [1:0]          i_sync,
    input logic [SAMPLE_W-1:0] i_smp,
    input logic                ctrl,
    input logic [1:0]          q_sync,
    input logic [SAMPLE_W-1:0] q_smp
  );
    logic [FRAME_W-1:0] f;
    f = '0;
    f[FR_IS_MSB:FR_IS_LSB] = i_sync;
    f[FR_I_MSB:FR_I_LSB]   = i_smp;
    f[FR_CTRL]             = ctrl;
    f[FR_QS_MSB:FR_QS_LSB] = q_sync;
    f[FR_Q_MSB:FR_Q_LSB]   = q_smp;
    return f;
  endfunction

endpackage

// File: rtl/lvds_tx.sv
// IQ transmit serializer: pulls one FIFO word per 16-clock frame, frames it with
// sync bits and shifts it out 2 bits per clock to the DDR output cell.
module lvds_tx
  import lvds_tx_pkg::*;
#(
  parameter logic [1:0]         I_SYNC     = LVDS_I_SYNC,
  parameter logic [1:0]         Q_SYNC     = LVDS_Q_SYNC,
  parameter logic               CTRL_BIT   = LVDS_CTRL_BIT,
  parameter logic [FRAME_W-1:0] IDLE_WORD  = LVDS_IDLE_WORD,
  parameter int unsigned        PULL_PHASE = 13
) (
  input  logic        i_ddr_clk,
  input  logic        i_rst_b,
  input  logic        i_tx_enable,
  input  logic        i_fifo_empty,
  input  logic [31:0] i_fifo_data,
  output logic        o_fifo_pull,
  output logic [1:0]  o_ddr_data,
  output logic        o_frame_start,
  output logic        o_busy,
  output logic        o_underrun,
  input  logic        i_underrun_clr
);

  localparam logic [PHASE_W-1:0] PULL_AT = PHASE_W'(PULL_PHASE);

  tx_state_t          state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0] next_q, next_d;
  logic [1:0]         ddr_q, ddr_d;
  logic               next_vld_q, next_vld_d;
  logic               pend_q, pend_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic               underrun_q, underrun_d;

  logic               decide, frame_end, active, pull;
  logic [FRAME_W-1:0] load_word;
  logic               unused_fifo_bits;

  assign unused_fifo_bits = ^{i_fifo_data[31:29], i_fifo_data[15:13]};

  always_comb begin
    phase_d    = phase_q + 1'b1;
    decide     = (phase_q == PULL_AT);
    frame_end  = (phase_q == LAST_PHASE);
    state_d    = state_q;
    if (decide) state_d = i_tx_enable ? ST_ACTIVE : ST_IDLE;
    // The decision uses the resulting state, so enable rising here pulls at once.
    active     = (state_d == ST_ACTIVE);
    pull       = decide && active && !i_fifo_empty;
    underrun_d = underrun_q;
    if (i_underrun_clr) underrun_d = 1'b0;
    if (decide && active && i_fifo_empty) underrun_d = 1'b1;
    pend_d     = pull;
    next_d     = next_q;
    next_vld_d = next_vld_q;
    if (pend_q) begin
      next_d = build_frame(I_SYNC, i_fifo_data[FIFO_I_MSB:FIFO_I_LSB], CTRL_BIT,
                           Q_SYNC, i_fifo_data[FIFO_Q_MSB:FIFO_Q_LSB]);
      next_vld_d = 1'b1;
    end
    load_word  = next_vld_q ? next_q : IDLE_WORD;
    busy_d     = busy_q;
    ddr_d      = shift_q[FRAME_W-1 -: 2];
    shift_d    = {shift_q[FRAME_W-3:0], 2'b00};
    if (frame_end) begin
      ddr_d      = load_word[FRAME_W-1 -: 2];
      shift_d    = {load_word[FRAME_W-3:0], 2'b00};
      busy_d     = next_vld_q;
      next_vld_d = 1'b0;
    end
    start_d    = frame_end;
  end

  always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      shift_q    <= '0;
      next_q     <= '0;
      ddr_q      <= 2'b00;
      next_vld_q <= 1'b0;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      shift_q    <= shift_d;
      next_q     <= next_d;
      ddr_q      <= ddr_d;
      next_vld_q <= next_vld_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      underrun_q <= underrun_d;
    end
  end

  assign o_fifo_pull   = pull;
  assign o_ddr_data    = ddr_q;
  assign o_frame_start = start_q;
  assign o_busy        = busy_q;
  assign o_underrun    = underrun_q;

endmodule

// File: tb/tb_lvds_tx.sv
// Bench for lvds_tx: FIFO model plus frame scoreboard, table of IQ vectors with
// hand-computed frames, and directed sequences for enable/reset/underrun corners.
module tb_lvds_tx;

  logic        i_ddr_clk = 1'b0;
  logic        i_rst_b = 1'b1;
  logic        i_tx_enable = 1'b0;
  logic        i_fifo_empty = 1'b1;
  logic [31:0] i_fifo_data = 32'h0;
  logic        i_underrun_clr = 1'b0;
  logic        o_fifo_pull;
  logic [1:0]  o_ddr_data;
  logic        o_frame_start;
  logic        o_busy;
  logic        o_underrun;

  lvds_tx dut (
    .i_ddr_clk      (i_ddr_clk),
    .i_rst_b        (i_rst_b),
    .i_tx_enable    (i_tx_enable),
    .i_fifo_empty   (i_fifo_empty),
    .i_fifo_data    (i_fifo_data),
    .o_fifo_pull    (o_fifo_pull),
    .o_ddr_data     (o_ddr_data),
    .o_frame_start  (o_frame_start),
    .o_busy         (o_busy),
    .o_underrun     (o_underrun),
    .i_underrun_clr (i_underrun_clr)
  );

  always #5 i_ddr_clk = ~i_ddr_clk;

  typedef struct {
    logic [12:0] i;
    logic [12:0] q;
    logic [31:0] frame;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] fifo_q[$];
  logic [31:0] fifo_exp_q[$];
  logic [31:0] exp_q[$];
  int          pull_cyc_q[$];

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          tb_phase = 0;
  int          n_pulls = 0;
  int          n_data_frames = 0;
  bit          first_frame = 1'b1;
  bit          pull_seen = 1'b0;
  logic        busy_frame = 1'b0;
  logic [31:0] frame_acc = 32'h0;
  logic        en_nx = 1'b0;
  logic        clr_nx = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout/none expected event (cycle %0d)", name, cyc);
  endtask

  // Scoreboard/monitor, called once per cycle at the falling edge.
  task automatic sample();
    logic [31:0] e;
    frame_acc = {frame_acc[29:0], o_ddr_data};
    if (tb_phase == 0) busy_frame = o_busy;
    else check("busy_stable", o_busy, busy_frame);
    check("frame_start", o_frame_start, (tb_phase == 0 && !first_frame));
    pull_seen = o_fifo_pull;
    if (o_fifo_pull) begin
      n_pulls++;
      pull_cyc_q.push_back(cyc);
      check("pull_not_empty", i_fifo_empty, 1'b0);
      check("pull_phase", tb_phase, 13);
    end
    if (tb_phase == 15) begin
      if (busy_frame) begin
        n_data_frames++;
        if (exp_q.size() == 0) fail("data_frame_unexpected");
        else begin
          e = exp_q.pop_front();
          check("data_frame", frame_acc, e);
        end
      end else begin
        check("idle_frame", frame_acc, 32'h0000_0000);
      end
    end
  endtask

  task automatic step();
    @(posedge i_ddr_clk);
    #1;
    cyc++;
    tb_phase = (tb_phase + 1) % 16;
    if (tb_phase == 0) first_frame = 1'b0;
    if (pull_seen && fifo_q.size() > 0) begin
      i_fifo_data = fifo_q.pop_front();
      exp_q.push_back(fifo_exp_q.pop_front());
    end
    i_fifo_empty   = (fifo_q.size() == 0);
    i_tx_enable    = en_nx;
    i_underrun_clr = clr_nx;
    @(negedge i_ddr_clk);
    sample();
  endtask

  task automatic do_reset(input int hold);
    i_rst_b = 1'b0;
    #1;
    check("rst_ddr", o_ddr_data, 2'b00);
    check("rst_busy", o_busy, 1'b0);
    check("rst_pull", o_fifo_pull, 1'b0);
    check("rst_start", o_frame_start, 1'b0);
    check("rst_underrun", o_underrun, 1'b0);
    repeat (hold) @(negedge i_ddr_clk);
    exp_q.delete();
    frame_acc   = 32'h0;
    tb_phase    = 0;
    first_frame = 1'b1;
    pull_seen   = 1'b0;
    i_rst_b     = 1'b1;
    sample();
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (tb_phase != p && n < 40) begin
      step();
      n++;
    end
    if (tb_phase != p) fail("wait_phase");
  endtask

  task automatic wait_busy_phase(input int p);
    int n = 0;
    while (!(o_busy === 1'b1 && tb_phase == p) && n < 400) begin
      step();
      n++;
    end
    if (!(o_busy === 1'b1 && tb_phase == p)) fail("wait_busy_phase");
  endtask

  task automatic push_vec(input int k);
    fifo_q.push_back({3'b111, vecs[k].i, 3'b111, vecs[k].q});
    fifo_exp_q.push_back(vecs[k].frame);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, d0, s0, rel_cyc;
    vecs[0] = '{13'h0ABC, 13'h1234, 32'h9578_6468};
    vecs[1] = '{13'h1FFF, 13'h1FFF, 32'hBFFE_7FFE};
    vecs[2] = '{13'h0000, 13'h0000, 32'h8000_4000};
    vecs[3] = '{13'h1000, 13'h0001, 32'hA000_4002};
    vecs[4] = '{13'h0555, 13'h0AAA, 32'h8AAA_5554};

    // Reset, then idle link with enable low.
    #2;
    do_reset(3);
    repeat (64) step();
    check("t1_no_pulls", n_pulls, 0);
    check("t1_no_data", n_data_frames, 0);
    check("t1_underrun", o_underrun, 1'b0);

    // Single word, then underrun and idle frame.
    push_vec(0);
    wait_phase(4);
    en_nx = 1'b1;
    step();
    p0 = n_pulls;
    d0 = n_data_frames;
    repeat (48) step();
    check("t2_pulls", n_pulls - p0, 1);
    check("t2_frames", n_data_frames - d0, 1);
    check("t2_underrun", o_underrun, 1'b1);
    check("t2_sb_empty", exp_q.size(), 0);
    en_nx = 1'b0;
    wait_phase(1);
    clr_nx = 1'b1;
    step();
    clr_nx = 1'b0;
    step();
    check("t2_clr", o_underrun, 1'b0);

    // Back-to-back table vectors, enable rising at the decision cycle.
    for (int k = 1; k < 5; k++) push_vec(k);
    wait_phase(12);
    en_nx = 1'b1;
    p0 = n_pulls;
    d0 = n_data_frames;
    s0 = pull_cyc_q.size();
    step();
    check("t3_pull_immediate", o_fifo_pull, 1'b1);
    repeat (70) step();
    check("t3_pulls", n_pulls - p0, 4);
    check("t3_frames", n_data_frames - d0, 4);
    if (pull_cyc_q.size() >= s0 + 4)
      for (int k = 1; k < 4; k++)
        check("t3_pull_gap", pull_cyc_q[s0+k] - pull_cyc_q[s0+k-1], 16);
    else fail("t3_pull_list");
    check("t3_underrun", o_underrun, 1'b1);
    wait_phase(2);
    clr_nx = 1'b1;
    step();
    clr_nx = 1'b0;
    step();
    check("t3_clr", o_underrun, 1'b0);

    // Underrun set and clear in the same cycle: set wins.
    p0 = n_pulls;
    wait_phase(12);
    check("t6_before", o_underrun, 1'b0);
    clr_nx = 1'b1;
    step();
    clr_nx = 1'b0;
    step();
    check("t6_set_wins", o_underrun, 1'b1);
    check("t6_no_pull", n_pulls - p0, 0);
    en_nx = 1'b0;
    wait_phase(12);
    step();
    step();

    // Enable drop mid-frame, then drop right after a prefetch.
    push_vec(0);
    push_vec(1);
    push_vec(2);
    p0 = n_pulls;
    d0 = n_data_frames;
    wait_phase(12);
    en_nx = 1'b1;
    step();
    wait_busy_phase(4);
    en_nx = 1'b0;
    step();
    repeat (40) step();
    check("t4a_pulls", n_pulls - p0, 1);
    check("t4a_frames", n_data_frames - d0, 1);
    check("t4a_fifo_left", fifo_q.size(), 2);
    wait_phase(12);
    en_nx = 1'b1;
    step();
    step();
    wait_phase(13);
    check("t4b_prefetch_pull", o_fifo_pull, 1'b1);
    en_nx = 1'b0;
    step();
    repeat (48) step();
    check("t4b_pulls", n_pulls - p0, 3);
    check("t4b_frames", n_data_frames - d0, 3);
    check("t4b_fifo_left", fifo_q.size(), 0);
    check("t4b_sb_empty", exp_q.size(), 0);

    // Reset mid data frame, then recovery.
    push_vec(1);
    push_vec(4);
    en_nx = 1'b1;
    wait_phase(12);
    step();
    wait_busy_phase(9);
    check("t5_pre_ddr", o_ddr_data, 2'b11);
    do_reset(2);
    rel_cyc = cyc;
    p0 = n_pulls;
    d0 = n_data_frames;
    check("t5_first_busy", o_busy, 1'b0);
    repeat (32) step();
    check("t5_pulls", n_pulls - p0, 1);
    if (n_pulls - p0 >= 1) check("t5_pull_cycle", pull_cyc_q[$] - rel_cyc, 13);
    check("t5_frames", n_data_frames - d0, 1);
    check("t5_sb_empty", exp_q.size(), 0);
    en_nx = 1'b0;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
